// File: rtl/image_stream_gen.sv
// Frame source: streams a stored RGB888 image from a synchronous pixel-pair RAM,
// two pixels per clock, with vsync lead-in and per-row blanking.
module image_stream_gen #(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int START_DELAY = 100,
    parameter int HSYNC_DELAY = 160,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [47:0]       mem_rdata,
    output logic              vsync,
    output logic              hsync,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic [7:0]        DATA_R1,
    output logic [7:0]        DATA_G1,
    output logic [7:0]        DATA_B1,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VSYNC = 3'd1,
        S_HSYNC = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int COLS    = WIDTH / 2;
    localparam int DLY_MAX = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int ROW_W   = $clog2(HEIGHT + 1);

    localparam logic [DLY_W-1:0]  SD_LAST  = DLY_W'(START_DELAY - 1);
    localparam logic [DLY_W-1:0]  HD_LAST  = DLY_W'(HSYNC_DELAY - 1);
    localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               rd_en_q, vsync_q, busy_q, done_q, hsync_q;
    logic [47:0]        hold_q;
    logic [47:0]        pix;

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q + DLY_ONE;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_VSYNC;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_VSYNC: if (dly_q == SD_LAST) state_d = S_HSYNC;
            S_HSYNC: if (dly_q == HD_LAST) state_d = S_DATA;
            S_DATA: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + ROW_ONE;
                        state_d = S_HSYNC;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) dly_d = '0;
        // The address for a DATA cycle is launched on the edge that enters it.
        if (state_d == S_DATA) begin
            mem_addr_d = addr_q;
            addr_d     = addr_q + ADDR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dly_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b0;
            vsync_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hsync_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            rd_en_q    <= (state_d == S_DATA);
            vsync_q    <= (state_d == S_VSYNC);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            hsync_q    <= rd_en_q;
            if (hsync_q) hold_q <= mem_rdata;
        end
    end

    // RAM data is valid in the hsync cycle itself: pass it through, then hold it.
    assign pix = hsync_q ? mem_rdata : hold_q;

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign vsync       = vsync_q;
    assign hsync       = hsync_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign dbg_state_o = state_q;
    assign DATA_R1     = pix[47:40];
    assign DATA_G1     = pix[39:32];
    assign DATA_B1     = pix[31:24];
    assign DATA_R0     = pix[23:16];
    assign DATA_G0     = pix[15:8];
    assign DATA_B0     = pix[7:0];

endmodule

// File: tb/tb_image_stream_gen.sv
// Directed bench for image_stream_gen with an 8x4 image and a synchronous RAM model.
module tb_image_stream_gen;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [47:0]   mem_rdata = '0;
    logic          vsync, hsync, busy, frame_done;
    logic [7:0]    r0, g0, b0, r1, g1, b1;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_addr = '0;
    logic [47:0]   exp_data = '0;

    image_stream_gen #(
        .WIDTH(8), .HEIGHT(4), .START_DELAY(3), .HSYNC_DELAY(2), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .vsync(vsync), .hsync(hsync),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
        .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .busy(busy), .frame_done(frame_done), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Word at address a has every byte equal to a+0x80.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= {6{8'h80 | {4'h0, mem_addr}}};
    end

    wire [47:0] data_out = {r1, g1, b1, r0, g0, b0};
    wire [56:0] all_outs = {vsync, hsync, mem_rd_en, busy, frame_done, mem_addr, data_out};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rd_at(int k);
        return (k >= 5) && (k <= 26) && (((k - 5) % 6) < 4);
    endfunction

    function automatic logic [AW-1:0] addr_at(int k);
        return AW'(((k - 5) / 6) * 4 + ((k - 5) % 6));
    endfunction

    // Issues start at edge E0 and checks cycles E0..E0+29 against the hand-derived timeline.
    task automatic run_frame(input int restart_at, input bit hold);
        int hs_cnt = 0;
        int fd_cnt = 0;
        bit e_rd, e_hs, e_vs, e_busy;
        start = 1'b1;
        step();
        start = hold;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) step();
            e_rd   = rd_at(k);
            e_hs   = (k >= 1) && rd_at(k - 1);
            e_vs   = (k <= 2) || (hold && k == 29);
            e_busy = (k <= 27) || (hold && k == 29);
            if (e_rd) exp_addr = addr_at(k);
            if (e_hs) exp_data = {6{8'h80 | {4'h0, addr_at(k - 1)}}};
            chk("vsync", 64'(vsync), 64'(e_vs));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("frame_done", 64'(frame_done), 64'(k == 27));
            chk("mem_rd_en", 64'(mem_rd_en), 64'(e_rd));
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
            chk("hsync", 64'(hsync), 64'(e_hs));
            chk("data", 64'(data_out), 64'(exp_data));
            hs_cnt += int'(hsync);
            fd_cnt += int'(frame_done);
            start = hold || (k + 1 == restart_at);
        end
        chk("hsync_count", 64'(hs_cnt), 64'd16);
        chk("done_count", 64'(fd_cnt), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        #2;
        chk("reset_outs", 64'(all_outs), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outs", 64'(all_outs), 64'd0);
        end

        run_frame(-1, 1'b0);
        step();
        chk("idle_after_frame", 64'({vsync, busy, mem_rd_en, hsync}), 64'd0);

        run_frame(10, 1'b0);
        step();
        chk("idle_after_repulse", 64'({vsync, busy, mem_rd_en, hsync}), 64'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("pre_reset_vsync", 64'(vsync), 64'd1);
        repeat (12) step();
        chk("pre_reset_hsync", 64'(hsync), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outs", 64'(all_outs), 64'd0);
        exp_addr = '0;
        exp_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", 64'(all_outs), 64'd0);
        end

        run_frame(-1, 1'b0);
        step();
        run_frame(-1, 1'b1);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("final_reset_outs", 64'(all_outs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
